arm1_datapath: RTL and testbench
================================

# arm1_datapath

Execution datapath of the ARM1 educational processor, directly downstream of the control unit. It holds the architectural registers (PC, IR, AC, B), the ALU with its result latch, a 16×8 unified program/data memory and an output port. It acts on the control unit's per-cycle enables and returns the current opcode. All storage is clocked on one edge; memory reads are combinational.

## Interface
Parameters:
- DW, 8, data and instruction width; instruction = opcode[7:4] | operand address[3:0]
- AW, 4, address width; memory depth = 2^AW = 16 words

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- pc_write  in  1  PC <= PC + 1 (mod 16)
- pc_sel  in  1  memory address select: 0 = PC, 1 = IR[3:0]
- res_sel  in  1  AC write source: 1 = memory read data, 0 = ALU result latch
- mem_write  in  1  mem[IR[3:0]] <= AC
- ir_write  in  1  IR <= mem[addr]
- ac_write  in  1  AC <= selected result
- b_write  in  1  B <= mem[addr]
- o_write  in  1  OUT <= AC
- alu_control  in  3  000 add, 001 sub, 010 and, 011 or, others pass AC
- prog_we  in  1  program-load write strobe
- prog_addr  in  AW  program-load address
- prog_data  in  DW  program-load data
- opcode  out  4  IR[7:4], to control unit
- out_data  out  DW  output port register
- out_valid  out  1  one-cycle pulse, high the cycle after OUT is written
- zero  out  1  zero flag
- carry  out  1  carry/borrow flag
- pc  out  AW  debug: current PC
- ac  out  DW  debug: current AC

## Operation
- Address mux: addr = pc_sel ? IR[3:0] : PC; rdata = mem[addr], combinational.
- ALU is combinational on AC and B; 8-bit result mod 256, 9th bit is carry. Sub = AC + ~B + 1; carry = 1 means no borrow. And/or/pass: carry = 0.
- ALU latch R captures the ALU result and carry every cycle, unconditionally.
- AC write: if res_sel = 1, AC <= rdata and zero <= (rdata == 0), carry unchanged. If res_sel = 0, AC <= R, zero <= (R == 0), carry <= latched carry.
- Flags change only on ac_write.
- Store: mem_write writes AC to mem[IR[3:0]] regardless of pc_sel.
- PC increments on pc_write and wraps from 15 to 0.
- OUT <= AC on o_write; out_valid is a registered copy of o_write.
- Program load: prog_we writes prog_data to mem[prog_addr]. If prog_we and mem_write are asserted in the same cycle, prog_we wins and the store is dropped, even when the addresses differ.
- Independent enables may assert together, and each takes effect. A read sees the pre-edge contents, so a same-cycle store is not visible to ir_write or b_write.

## Timing
- Every register write takes effect on the rising edge that ends the cycle in which its enable is high. The new value is visible the following cycle.
- Fetch: ir_write in cycle n loads mem[PC]. pc_write in cycle n+1 advances PC. opcode is valid from cycle n+1.
- ALU path: AC/B are stable in cycle n with alu_control set, R latches at the end of n, and ac_write with res_sel = 0 in cycle n+1 commits it to AC. Latency is 2 cycles from operands to AC.
- Load/store: 1 cycle, with pc_sel = 1 in that cycle.
- Reset (synchronous, mid-operation allowed): PC, IR, AC, B, R, OUT, zero, carry and out_valid all go to 0, giving opcode = 0, out_data = 0, pc = 0 and ac = 0.
- Memory contents are not affected by reset. Enables in the reset cycle are ignored, including prog_we.

## Test plan
- Reset: after arbitrary activity, assert reset for 1 cycle -> all outputs 0 the next cycle; a preloaded memory word is read back unchanged.
- Fetch/wrap: load mem[0] = 0xC8, then ir_write, then pc_write -> opcode = 0xC, pc = 1. Apply 15 further pc_write -> pc wraps to 0.
- Load and add: mem[8] = 0x05, mem[9] = 0xFC. Load AC from 8, load B from 9, then alu_control = 000 for a cycle, then ac_write with res_sel = 0 -> AC = 0x01, carry = 1, zero = 0.
- Sub zero: AC = 0x07, B = 0x07, sub -> AC = 0x00, zero = 1, carry = 1. With AC = 0x03, B = 0x05 -> AC = 0xFE, carry = 0.
- Store/output: IR = 0xEA, AC = 0x5A, mem_write -> mem[10] = 0x5A. Then o_write -> out_data = 0x5A, out_valid high exactly 1 cycle.
- Collision: prog_we to address 3 with data 0x11 and mem_write to address 10 in the same cycle -> mem[3] = 0x11, mem[10] unchanged.

Source files
------------

// File: rtl/arm1_datapath.sv
// arm1_datapath
// Execution datapath of the ARM1 educational processor. It holds the
// architectural registers (PC, IR, AC, B), a combinational ALU with a
// result latch R, a 16-word unified program/data memory and an output
// port register. It acts on the control unit's per-cycle enables and
// returns the current opcode.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   pc_write            - PC <= PC + 1 (wraps mod 2^AW)
//   pc_sel              - memory address: 0 = PC, 1 = IR operand field
//   res_sel             - AC source: 1 = memory read data, 0 = ALU latch R
//   mem_write           - mem[IR operand] <= AC
//   ir_write, b_write   - IR / B <= mem[addr]
//   ac_write            - AC <= selected source, flags updated
//   o_write             - OUT <= AC
//   alu_control         - 000 add, 001 sub, 010 and, 011 or, else pass AC
//   prog_we/addr/data   - program-load port, has priority over mem_write
//   opcode              - IR[7:4] to the control unit
//   out_data, out_valid - output register and its one-cycle strobe
//   zero, carry         - flags, change only on ac_write
//   pc, ac              - debug views of PC and AC
//
// out_valid semantics: out_valid is high for exactly the one cycle that
// follows a cycle with o_write high; out_data holds the new value from
// that cycle on. There is no back-pressure.
module arm1_datapath #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_write,
    input  logic          pc_sel,
    input  logic          res_sel,
    input  logic          mem_write,
    input  logic          ir_write,
    input  logic          ac_write,
    input  logic          b_write,
    input  logic          o_write,
    input  logic [2:0]    alu_control,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic [3:0]    opcode,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          zero,
    output logic          carry,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] ac
);

    logic [AW-1:0] pc_q;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] ac_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] r_q;
    logic          r_carry_q;
    logic [DW-1:0] out_q;
    logic          out_valid_q;
    logic          zero_q;
    logic          carry_q;

    logic [DW-1:0] mem [2**AW];

    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic [DW:0]   alu_res;

    // Operand field of the instruction addresses data memory.
    assign addr  = pc_sel ? ir_q[AW-1:0] : pc_q;
    assign rdata = mem[addr];

    // 9-bit ALU result; bit DW is the carry. Subtract is AC + ~B + 1, so
    // carry = 1 means no borrow.
    always_comb begin
        alu_res = {1'b0, ac_q};
        case (alu_control)
            3'b000:  alu_res = {1'b0, ac_q} + {1'b0, b_q};
            3'b001:  alu_res = {1'b0, ac_q} + {1'b0, ~b_q} + (DW+1)'(1);
            3'b010:  alu_res = {1'b0, ac_q & b_q};
            3'b011:  alu_res = {1'b0, ac_q | b_q};
            default: alu_res = {1'b0, ac_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= '0;
            ir_q        <= '0;
            ac_q        <= '0;
            b_q         <= '0;
            r_q         <= '0;
            r_carry_q   <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            // R follows the ALU every cycle; AC only commits it on ac_write.
            r_q         <= alu_res[DW-1:0];
            r_carry_q   <= alu_res[DW];
            out_valid_q <= o_write;
            if (pc_write) pc_q <= pc_q + AW'(1);
            if (ir_write) ir_q <= rdata;
            if (b_write)  b_q  <= rdata;
            if (o_write)  out_q <= ac_q;
            if (ac_write) begin
                if (res_sel) begin
                    // Memory loads leave carry alone.
                    ac_q   <= rdata;
                    zero_q <= (rdata == '0);
                end else begin
                    ac_q    <= r_q;
                    zero_q  <= (r_q == '0);
                    carry_q <= r_carry_q;
                end
            end
        end
    end

    // Memory is not cleared by reset, but writes are blocked in the reset
    // cycle. Program load wins over a store even to a different address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (prog_we) begin
                mem[prog_addr] <= prog_data;
            end else if (mem_write) begin
                mem[ir_q[AW-1:0]] <= ac_q;
            end
        end
    end

    assign opcode    = ir_q[DW-1 -: 4];
    assign out_data  = out_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign pc        = pc_q;
    assign ac        = ac_q;

endmodule

// File: tb/tb_arm1_datapath.sv
// Directed testbench for arm1_datapath. Expected values are pushed to a
// scoreboard queue as each step is driven and popped when the outputs
// are sampled one time unit after the following rising edge.
module tb_arm1_datapath;

  localparam int DW = 8;
  localparam int AW = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          pc_write, pc_sel, res_sel, mem_write;
  logic          ir_write, ac_write, b_write, o_write;
  logic [2:0]    alu_control;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic [3:0]    opcode;
  logic [DW-1:0] out_data;
  logic          out_valid, zero, carry;
  logic [AW-1:0] pc;
  logic [DW-1:0] ac;

  arm1_datapath #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .pc_write(pc_write), .pc_sel(pc_sel), .res_sel(res_sel),
    .mem_write(mem_write), .ir_write(ir_write), .ac_write(ac_write),
    .b_write(b_write), .o_write(o_write), .alu_control(alu_control),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode), .out_data(out_data), .out_valid(out_valid),
    .zero(zero), .carry(carry), .pc(pc), .ac(ac)
  );

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic sb_push(input logic [DW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] exp_v;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pc_write = 0; pc_sel = 0; res_sel = 0; mem_write = 0;
    ir_write = 0; ac_write = 0; b_write = 0; o_write = 0;
    alu_control = 3'b000; prog_we = 0; prog_addr = '0; prog_data = '0;
  endtask

  task automatic prog(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    step();
    prog_we = 0;
  endtask

  // PC is kept at 0 outside the wrap test, so mem[0] is the IR scratch slot.
  task automatic set_ir(input logic [DW-1:0] v);
    prog(4'd0, v);
    pc_sel = 0; ir_write = 1;
    step();
    ir_write = 0;
  endtask

  task automatic load_ac(input logic [AW-1:0] a);
    set_ir({4'h1, a});
    pc_sel = 1; res_sel = 1; ac_write = 1;
    step();
    pc_sel = 0; res_sel = 0; ac_write = 0;
  endtask

  task automatic load_b(input logic [AW-1:0] a);
    set_ir({4'h2, a});
    pc_sel = 1; b_write = 1;
    step();
    pc_sel = 0; b_write = 0;
  endtask

  task automatic alu_op(input logic [2:0] ctl);
    alu_control = ctl;
    step();
    res_sel = 0; ac_write = 1;
    step();
    ac_write = 0; alu_control = 3'b000;
  endtask

  task automatic check_flags(input string tag, input logic [DW-1:0] ac_e,
                             input logic z_e, input logic c_e);
    sb_push(ac_e);        sb_check({tag, "_ac"}, ac);
    sb_push(8'(z_e));     sb_check({tag, "_zero"}, 8'(zero));
    sb_push(8'(c_e));     sb_check({tag, "_carry"}, 8'(carry));
  endtask

  task automatic check_reset_state(input string tag);
    sb_push(8'h00); sb_check({tag, "_opcode"}, 8'(opcode));
    sb_push(8'h00); sb_check({tag, "_out_data"}, out_data);
    sb_push(8'h00); sb_check({tag, "_out_valid"}, 8'(out_valid));
    sb_push(8'h00); sb_check({tag, "_zero"}, 8'(zero));
    sb_push(8'h00); sb_check({tag, "_carry"}, 8'(carry));
    sb_push(8'h00); sb_check({tag, "_pc"}, 8'(pc));
    sb_push(8'h00); sb_check({tag, "_ac"}, ac);
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    check_reset_state("por");

    // fetch and PC wrap
    prog(4'd0, 8'hC8);
    ir_write = 1; pc_sel = 0;
    step();
    ir_write = 0; pc_write = 1;
    step();
    pc_write = 0;
    sb_push(8'h0C); sb_check("fetch_opcode", 8'(opcode));
    sb_push(8'h01); sb_check("fetch_pc", 8'(pc));
    pc_write = 1;
    for (int i = 0; i < 14; i++) step();
    pc_write = 0;
    sb_push(8'h0F); sb_check("pc_15", 8'(pc));
    pc_write = 1;
    step();
    pc_write = 0;
    sb_push(8'h00); sb_check("pc_wrap", 8'(pc));

    // load and add
    prog(4'd8, 8'h05);
    prog(4'd9, 8'hFC);
    load_ac(4'd8);
    check_flags("load8", 8'h05, 1'b0, 1'b0);
    load_b(4'd9);
    alu_op(3'b000);
    check_flags("add", 8'h01, 1'b0, 1'b1);

    // subtract to zero; memory load keeps carry
    prog(4'd8, 8'h07);
    prog(4'd9, 8'h07);
    load_ac(4'd8);
    check_flags("load7", 8'h07, 1'b0, 1'b1);
    load_b(4'd9);
    alu_op(3'b001);
    check_flags("sub_zero", 8'h00, 1'b1, 1'b1);

    // subtract with borrow, then logic ops and pass
    prog(4'd8, 8'h03);
    prog(4'd9, 8'h05);
    load_ac(4'd8);
    load_b(4'd9);
    alu_op(3'b001);
    check_flags("sub_borrow", 8'hFE, 1'b0, 1'b0);
    alu_op(3'b010);
    check_flags("and", 8'h04, 1'b0, 1'b0);
    alu_op(3'b011);
    check_flags("or", 8'h05, 1'b0, 1'b0);
    alu_op(3'b111);
    check_flags("pass", 8'h05, 1'b0, 1'b0);

    // store and output
    prog(4'd11, 8'h5A);
    load_ac(4'd11);
    set_ir(8'hEA);
    sb_push(8'h0E); sb_check("store_opcode", 8'(opcode));
    mem_write = 1; pc_sel = 0;
    step();
    mem_write = 0;
    o_write = 1;
    step();
    o_write = 0;
    sb_push(8'h5A); sb_check("out_data", out_data);
    sb_push(8'h01); sb_check("out_valid_hi", 8'(out_valid));
    step();
    sb_push(8'h00); sb_check("out_valid_lo", 8'(out_valid));
    sb_push(8'h5A); sb_check("out_data_hold", out_data);
    prog(4'd11, 8'h33);
    load_ac(4'd11);
    sb_push(8'h33); sb_check("ac_33", ac);
    load_ac(4'd10);
    sb_push(8'h5A); sb_check("store_readback", ac);

    // prog_we and mem_write collide: store is dropped
    load_ac(4'd11);
    set_ir(8'hEA);
    prog_we = 1; prog_addr = 4'd3; prog_data = 8'h11; mem_write = 1;
    step();
    prog_we = 0; mem_write = 0;
    load_ac(4'd3);
    sb_push(8'h11); sb_check("collide_mem3", ac);
    load_ac(4'd10);
    sb_push(8'h5A); sb_check("collide_mem10", ac);

    // mid-operation reset with enables asserted
    prog(4'd12, 8'hF0);
    load_ac(4'd12);
    load_b(4'd12);
    alu_op(3'b000);
    check_flags("add_carry", 8'hE0, 1'b0, 1'b1);
    o_write = 1;
    step();
    o_write = 0;
    pc_write = 1;
    step();
    sb_push(8'h01); sb_check("pre_reset_pc", 8'(pc));
    reset = 1; o_write = 1; ac_write = 1; ir_write = 1;
    prog_we = 1; prog_addr = 4'd3; prog_data = 8'h77;
    step();
    reset = 0;
    clear_inputs();
    check_reset_state("mid_reset");
    load_ac(4'd3);
    sb_push(8'h11); sb_check("mem_survives_reset", ac);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
